sync_reg_reader: RTL
====================

SYNC_REG_READER -- requirements
Module: sync_reg_reader

Interface
REQ-001 SHALL have parameter SIZE, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: capture FIFO entries; power of two, >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; clock port r_clk, reset port rst.
REQ-004 Ports, clock and reset first:
- r_clk  input  1  sole clock; all state rising-edge triggered
- rst  input  1  asynchronous reset, active-high
- r_data  input  SIZE  read-side data word from the upstream synchronising register
- r_empty  input  1  upstream empty flag; a high-to-low transition marks a new word
- out_data  output  SIZE  FIFO head word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  downstream accepts head word
- count  output  clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full

Function
REQ-005 SHALL register r_empty each cycle into empty_q.
REQ-006 SHALL detect a new word (push) in any cycle where r_empty==0 and empty_q==1.
REQ-007 On push, SHALL sample r_data in that same cycle and write it at the FIFO tail.
- A word pushed at edge N appears on out_data with out_valid=1 after edge N, at the latest when the FIFO was empty.
REQ-008 r_empty held low for multiple cycles SHALL produce exactly one push.
- r_data changes while r_empty stays low SHALL be ignored.
REQ-009 out_valid SHALL equal (count != 0); out_data SHALL be the oldest unread word; both driven from registers and pointers, with no combinational path from out_ready.
REQ-010 Pop SHALL occur when out_valid && out_ready; the head SHALL advance at that edge.
REQ-011 Push with count==DEPTH and no pop SHALL discard the word, leave FIFO contents and count unchanged, and set overflow=1.
REQ-012 Simultaneous push and pop with count==DEPTH SHALL accept the push; count stays DEPTH and overflow is not set.
REQ-013 Simultaneous push and pop with count==0 is impossible, because out_valid=0; the push SHALL be stored and count becomes 1.
REQ-014 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-015 count SHALL track the cycle result:
- +1 on push only
- -1 on pop only
- unchanged on both or neither, or on a dropped push
REQ-016 overflow SHALL remain 1 until reset; no other clear mechanism exists.

Reset
REQ-017 While rst=1 SHALL force, asynchronously:
- out_valid=0, count=0, overflow=0
- read and write pointers to 0
- empty_q=1
- out_data=0
REQ-018 If r_empty=0 at the first edge after rst deasserts, that edge SHALL count as a push, because empty_q resets to 1.
REQ-019 Asserting rst mid-operation SHALL discard all buffered words; no partial pop or push completes.

Configuration
REQ-020 Macro SYNC_REG_READER_DROP_CNT_EN.
REQ-021 Defined: SHALL add output drop_cnt, 8 bits, reset 0.
- Increments on each discarded push (REQ-011).
- Saturates at 255.
REQ-022 Undefined: drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Reset then single word: r_empty 1->0 with r_data=8'hBB, out_ready=0 -> next cycle out_valid=1, out_data=8'hBB, count=1.
REQ-024 Held empty: r_empty low for 10 cycles while r_data changes 8'h11->8'h22 -> exactly one entry (8'h11), count=1.
REQ-025 Fill and overflow, DEPTH=4, out_ready=0: push 8'h01..8'h05 -> count=4, head 8'h01, overflow=1; drop_cnt=1 when macro defined.
REQ-026 Full plus simultaneous pop: count=4, push 8'hA5 with out_ready=1 -> count stays 4, overflow stays 0, head becomes next word, 8'hA5 at tail.
REQ-027 Wrap-around: 9 push/pop pairs of 8'h10..8'h18 -> pops occur in order 8'h10..8'h18, count returns to 0, out_valid=0.
REQ-028 Reset mid-operation: count=3, assert rst -> same cycle out_valid=0, count=0, overflow=0; release with r_empty=0 -> one push captured.

Source files
------------

// File: rtl/sync_reg_reader.sv
// Captures each new word from an upstream synchronising register into a small FIFO.
// Latency: a captured word is visible on out_data/out_valid one edge after capture when the FIFO was empty.
// Backpressure: out_valid/out_ready handshake; a word captured while full with no pop is dropped and flagged.
// Optional feature: define SYNC_REG_READER_DROP_CNT_EN to add the saturating 8-bit drop_cnt output.
module sync_reg_reader #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     r_clk,
  input  logic                     rst,
  input  logic [SIZE-1:0]          r_data,
  input  logic                     r_empty,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef SYNC_REG_READER_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic              empty_q, empty_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [SIZE-1:0]   mem_q [DEPTH];
  logic [SIZE-1:0]   mem_d [DEPTH];

  logic push, pop, full, accept, drop;

  // Falling edge of the upstream empty flag marks exactly one new word; the
  // word is taken at the tail when there is room (or the head leaves this cycle).
  always_comb begin
    empty_d = r_empty;
    push    = !r_empty && empty_q;
    pop     = (count_q != '0) && out_ready;
    full    = (count_q == FULL_CNT);
    accept  = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // Next-state for storage, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (accept) begin
      mem_d[wr_ptr_q] = r_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and arms empty_q so a low r_empty
  // at the first edge after reset is taken as a new word.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      empty_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      empty_q    <= empty_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  // Outputs come straight from state; out_ready never reaches them combinationally.
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef SYNC_REG_READER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of words discarded because the FIFO was full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
